mod_phase_gen: RTL

- Downstream consumer of the configuration register bank (control, modulating frequency, carrier frequency, AM index, FM index) written over the serial link.
- Shadows the register values and applies them only on sample-tick boundaries, so an update never lands mid-sample.
- Runs two phase accumulators: a modulating tone and an FM-modulated carrier. Their phase words feed the sine LUTs of the AM/FM modulator datapath.

---
 rtl/mod_phase_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mod_phase_gen.sv
// mod_phase_gen: shadows the configuration register bank and applies updates
// only on sample-tick boundaries, then runs two phase accumulators (modulating
// tone and FM-modulated carrier) whose phase words address the sine LUTs.
// Optional feature macro PHASE_DITHER_EN: adds a 16-bit LFSR whose low byte
// dithers the carrier phase output (the accumulator itself stays clean).
module mod_phase_gen #(
    parameter int NDIV = 50,
    parameter int PW   = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    r_control,
    input  logic [PW-1:0] r_frec_mod,
    input  logic [PW-1:0] r_frec_por,
    input  logic [15:0]   r_im_am,
    input  logic [15:0]   r_im_fm,
    input  logic          load_confregs,
    input  logic [15:0]   mod_wave,
    output logic          sample_tick,
    output logic [PW-1:0] phase_mod,
    output logic [PW-1:0] phase_por,
    output logic [15:0]   im_am_out,
    output logic          am_en,
    output logic          running,
    output logic          cfg_pending
);

    localparam logic [15:0] CNT_LAST = 16'(NDIV - 1);

    // Shadowed configuration. Phase-reset (control bit7) is deliberately not
    // stored: it only acts on the apply tick, which makes it one-shot.
    typedef struct packed {
        logic          run;
        logic          am;
        logic          fm;
        logic [PW-1:0] frec_mod;
        logic [PW-1:0] frec_por;
        logic [15:0]   im_am;
        logic [15:0]   im_fm;
    } cfg_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    logic [15:0]        cnt;
    logic               tick;
    logic               pend;
    logic               apply;
    logic               phase_rst;
    cfg_t               sh;
    cfg_t               cfg_in;
    cfg_t               eff;
    state_t             state;
    state_t             state_nx;
    logic [PW-1:0]      acc_mod;
    logic [PW-1:0]      acc_por;
    logic [PW-1:0]      acc_mod_nx;
    logic [PW-1:0]      acc_por_nx;
    logic [PW-1:0]      fm_term;
    logic signed [32:0] fm_prod;
    logic               unused_ctrl;

    // Control bits 6:3 carry no function here.
    assign unused_ctrl = ^r_control[6:3];

    // Free-running sample tick counter, 0..NDIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 16'd1;
    end

    assign tick        = (cnt == CNT_LAST);
    assign sample_tick = tick;

    // A load coincident with the tick is not applied: its register values
    // only become valid the following cycle, so it waits one more tick.
    assign apply     = tick & pend & ~load_confregs;
    assign phase_rst = apply & r_control[7];

    // Pending-update flag; repeated loads collapse into one apply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               pend <= 1'b0;
        else if (load_confregs) pend <= 1'b1;
        else if (apply)         pend <= 1'b0;
    end

    // Incoming register bank view.
    always_comb begin
        cfg_in          = '0;
        cfg_in.run      = r_control[0];
        cfg_in.am       = r_control[1];
        cfg_in.fm       = r_control[2];
        cfg_in.frec_mod = r_frec_mod;
        cfg_in.frec_por = r_frec_por;
        cfg_in.im_am    = r_im_am;
        cfg_in.im_fm    = r_im_fm;
    end

    // Values the tick logic acts on: shadows after any same-tick apply.
    assign eff = apply ? cfg_in : sh;

    // Shadow registers, loaded only on an apply tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       sh <= '0;
        else if (apply) sh <= cfg_in;
    end

    // FM term: signed sample times unsigned Q1.15 index, scaled back by 2^15.
    always_comb begin
        fm_prod = 33'($signed(mod_wave)) * 33'($signed({1'b0, eff.im_fm}));
        fm_term = eff.fm ? PW'(fm_prod >>> 15) : '0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // FSM next state and accumulator updates, all gated to tick cycles.
    always_comb begin
        state_nx   = state;
        acc_mod_nx = acc_mod;
        acc_por_nx = acc_por;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    acc_mod_nx = '0;
                    acc_por_nx = '0;
                    if (eff.run) state_nx = S_ARM;
                end
                S_ARM: begin
                    acc_mod_nx = '0;
                    acc_por_nx = '0;
                    state_nx   = S_RUN;
                end
                S_RUN: begin
                    if (!eff.run) begin
                        acc_mod_nx = '0;
                        acc_por_nx = '0;
                        state_nx   = S_IDLE;
                    end else if (phase_rst) begin
                        acc_mod_nx = '0;
                        acc_por_nx = '0;
                    end else begin
                        acc_mod_nx = acc_mod + eff.frec_mod;
                        acc_por_nx = acc_por + eff.frec_por + fm_term;
                    end
                end
                default: begin
                    acc_mod_nx = '0;
                    acc_por_nx = '0;
                    state_nx   = S_IDLE;
                end
            endcase
        end
    end

    // Phase accumulators; wrap modulo 2^PW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_mod <= '0;
            acc_por <= '0;
        end else begin
            acc_mod <= acc_mod_nx;
            acc_por <= acc_por_nx;
        end
    end

    assign running     = (state == S_RUN);
    assign am_en       = running & sh.am;
    assign im_am_out   = am_en ? sh.im_am : '0;
    assign cfg_pending = pend;
    assign phase_mod   = acc_mod;

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per running sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       lfsr <= 16'hACE1;
        else if (tick && running)       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign phase_por = acc_por + PW'(lfsr[7:0]);
`else
    assign phase_por = acc_por;
`endif

endmodule
